logic_bist_ctrl: RTL and testbench

Built-in self-test controller for the 3-input/2-output combinational logic block (inputs A,B,C; outputs P,Q).
- On a start pulse it drives all 8 input vectors in order onto the block.
- After a settle interval it samples P/Q for each vector and compares them against golden values computed internally.
- It then reports pass/fail, the mismatch count and the first failing vector.
- It sits beside the logic block and owns its inputs during test.

---
 rtl/logic_bist_ctrl_if.sv | 29 ++
 rtl/logic_bist_ctrl.sv | 155 +++++++++++++++
 tb/tb_logic_bist_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_bist_ctrl_if.sv
// Control/status and DUT-facing signal bundle for the logic BIST controller.
// The master side is the test host plus the logic block; the slave side is the controller.
interface logic_bist_ctrl_if;
    logic       start;
    logic       abort;
    logic       p_in;
    logic       q_in;
    logic       a_out;
    logic       b_out;
    logic       c_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic [2:0] first_fail_vec;
    logic       first_fail_valid;

    modport master (
        output start, abort, p_in, q_in,
        input  a_out, b_out, c_out, busy, done, pass,
               err_count, first_fail_vec, first_fail_valid
    );

    modport slave (
        input  start, abort, p_in, q_in,
        output a_out, b_out, c_out, busy, done, pass,
               err_count, first_fail_vec, first_fail_valid
    );
endinterface

// File: rtl/logic_bist_ctrl.sv
// Exhaustive BIST for the 3-in/2-out logic block: walks all 8 {A,B,C} vectors,
// compares P/Q against an internal golden model and reports pass/fail details.
module logic_bist_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input logic                clk,
    input logic                n_reset,
    logic_bist_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] err_q, err_d;
    logic [2:0] ffv_q, ffv_d;
    logic       ffvalid_q, ffvalid_d;
    logic       pass_q, pass_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [2:0] drv_q, drv_d;

    logic       exp_p, exp_q, mismatch;
    logic [3:0] err_new;

    assign exp_p    = ~vec_q[1] & (vec_q[2] | vec_q[0]);
    assign exp_q    = ~vec_q[2] & (~vec_q[1] | ~vec_q[0]);
    assign mismatch = (bus.p_in != exp_p) || (bus.q_in != exp_q);
    assign err_new  = err_q + {3'b000, mismatch};

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= IDLE;
            vec_q     <= '0;
            cnt_q     <= '0;
            err_q     <= '0;
            ffv_q     <= '0;
            ffvalid_q <= 1'b0;
            pass_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            drv_q     <= '0;
        end else begin
            // NOTE: non-blocking so every register sees pre-edge values of the others.
            state_q   <= state_d;
            vec_q     <= vec_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            ffv_q     <= ffv_d;
            ffvalid_q <= ffvalid_d;
            pass_q    <= pass_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            drv_q     <= drv_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d   = state_q;
        vec_d     = vec_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        ffv_d     = ffv_q;
        ffvalid_d = ffvalid_q;
        pass_d    = pass_q;
        busy_d    = 1'b0;
        done_d    = done_q;
        drv_d     = '0;

        unique case (state_q)
            IDLE, DONE: begin
                // Abort alongside start suppresses the run; abort alone is a no-op here.
                if (bus.start && !bus.abort) begin
                    state_d   = SETTLE;
                    vec_d     = '0;
                    cnt_d     = SETTLE_INIT;
                    err_d     = '0;
                    ffv_d     = '0;
                    ffvalid_d = 1'b0;
                    pass_d    = 1'b0;
                    done_d    = 1'b0;
                    busy_d    = 1'b1;
                end
            end

            SETTLE: begin
                if (bus.abort) begin
                    state_d   = IDLE;
                    vec_d     = '0;
                    err_d     = '0;
                    ffv_d     = '0;
                    ffvalid_d = 1'b0;
                    pass_d    = 1'b0;
                    done_d    = 1'b0;
                end else begin
                    busy_d = 1'b1;
                    drv_d  = vec_q;
                    if (cnt_q == 4'd0) state_d = SAMPLE;
                    else               cnt_d   = cnt_q - 4'd1;
                end
            end

            SAMPLE: begin
                if (bus.abort) begin
                    state_d   = IDLE;
                    vec_d     = '0;
                    err_d     = '0;
                    ffv_d     = '0;
                    ffvalid_d = 1'b0;
                    pass_d    = 1'b0;
                    done_d    = 1'b0;
                end else begin
                    err_d = err_new;
                    if (mismatch && !ffvalid_q) begin
                        ffv_d     = vec_q;
                        ffvalid_d = 1'b1;
                    end
                    if (vec_q == 3'd7) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = (err_new == 4'd0);
                    end else begin
                        state_d = SETTLE;
                        vec_d   = vec_q + 3'd1;
                        cnt_d   = SETTLE_INIT;
                        busy_d  = 1'b1;
                        drv_d   = vec_q + 3'd1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.a_out            = drv_q[2];
    assign bus.b_out            = drv_q[1];
    assign bus.c_out            = drv_q[0];
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.err_count        = err_q;
    assign bus.first_fail_vec   = ffv_q;
    assign bus.first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_logic_bist_ctrl.sv
// Directed bench for logic_bist_ctrl: a behavioural logic block with selectable
// stuck-at faults feeds P/Q back; expected results are hand-derived constants.
module tb_logic_bist_ctrl;

    logic clk;
    logic n_reset;
    int   errors = 0;
    int   checks = 0;
    int   fault  = 0;   // 0 good, 1 Q stuck-0, 2 P stuck-0, 3 P stuck-1

    // Golden truth table of the block, bit i = vector {A,B,C} == i.
    localparam logic [7:0] GOLD_P = 8'b0011_0010;
    localparam logic [7:0] GOLD_Q = 8'b0000_0111;

    logic_bist_ctrl_if bus0();
    logic_bist_ctrl_if bus1();

    logic [2:0] v0, v1;
    assign v0 = {bus0.a_out, bus0.b_out, bus0.c_out};
    assign v1 = {bus1.a_out, bus1.b_out, bus1.c_out};

    always_comb begin
        bus0.p_in = GOLD_P[v0];
        bus0.q_in = GOLD_Q[v0];
        case (fault)
            1:       bus0.q_in = 1'b0;
            2:       bus0.p_in = 1'b0;
            3:       bus0.p_in = 1'b1;
            default: ;
        endcase
    end

    assign bus1.p_in = GOLD_P[v1];
    assign bus1.q_in = GOLD_Q[v1];

    logic_bist_ctrl #(.SETTLE_CYCLES(2)) dut0 (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus0)
    );

    logic_bist_ctrl #(.SETTLE_CYCLES(1)) dut1 (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {busy, done, pass, first_fail_valid, err_count, first_fail_vec, drive}
    function automatic logic [13:0] st0();
        return {bus0.busy, bus0.done, bus0.pass, bus0.first_fail_valid,
                bus0.err_count, bus0.first_fail_vec, v0};
    endfunction

    function automatic logic [13:0] st1();
        return {bus1.busy, bus1.done, bus1.pass, bus1.first_fail_valid,
                bus1.err_count, bus1.first_fail_vec, v1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start (captured at edge 1) and wait for done; e = edge at which done was seen.
    task automatic run0(output int e);
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        e = 1;
        while (bus0.done !== 1'b1 && e < 200) begin
            tick();
            e++;
        end
        checks++;
        if (bus0.done !== 1'b1) begin
            errors++;
            $display("FAIL run0_timeout: done=%b after %0d edges, required 1", bus0.done, e);
        end
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        bus0.start = 1'b0; bus0.abort = 1'b0;
        bus1.start = 1'b0; bus1.abort = 1'b0;
        #2;
        checks++;
        if (st0() !== 14'd0) begin errors++; $display("FAIL reset_dut0: status=%b required 0", st0()); end
        checks++;
        if (st1() !== 14'd0) begin errors++; $display("FAIL reset_dut1: status=%b required 0", st1()); end
        @(negedge clk);
        n_reset = 1'b1;
        tick();
        tick();
        checks++;
        if (st0() !== 14'd0) begin errors++; $display("FAIL idle_after_reset: status=%b required 0", st0()); end
    endtask

    task automatic test_good_run();
        logic [13:0] exp_final;
        fault = 0;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        for (int e = 1; e <= 24; e++) begin
            logic [4:0] exp_seq;
            exp_seq = {1'b1, 1'b0, 3'((e - 1) / 3)};
            checks++;
            if ({bus0.busy, bus0.done, v0} !== exp_seq) begin
                errors++;
                $display("FAIL good_seq edge %0d: {busy,done,drv}=%b required %b", e, {bus0.busy, bus0.done, v0}, exp_seq);
            end
            tick();
        end
        exp_final = {1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 3'd0, 3'd0};
        checks++;
        if (st0() !== exp_final) begin
            errors++;
            $display("FAIL good_done edge 25: status=%b required %b", st0(), exp_final);
        end
    endtask

    task automatic test_q_stuck0();
        int e;
        fault = 1;
        run0(e);
        checks++;
        if (e != 25) begin errors++; $display("FAIL qs0_latency: got %0d required 25", e); end
        checks++;
        if ({bus0.pass, bus0.first_fail_valid, bus0.err_count, bus0.first_fail_vec} !== {1'b0, 1'b1, 4'd3, 3'd0}) begin
            errors++;
            $display("FAIL qs0_result: pass=%b ffvalid=%b err=%0d ffv=%0d required 0 1 3 0",
                     bus0.pass, bus0.first_fail_valid, bus0.err_count, bus0.first_fail_vec);
        end
    endtask

    task automatic test_p_stuck0();
        int e;
        fault = 2;
        run0(e);
        checks++;
        if ({bus0.pass, bus0.first_fail_valid, bus0.err_count, bus0.first_fail_vec} !== {1'b0, 1'b1, 4'd3, 3'd1}) begin
            errors++;
            $display("FAIL ps0_result: pass=%b ffvalid=%b err=%0d ffv=%0d required 0 1 3 1",
                     bus0.pass, bus0.first_fail_valid, bus0.err_count, bus0.first_fail_vec);
        end
    endtask

    task automatic test_p_stuck1_restart();
        int e;
        fault = 3;
        run0(e);
        checks++;
        if ({bus0.pass, bus0.first_fail_valid, bus0.err_count, bus0.first_fail_vec} !== {1'b0, 1'b1, 4'd5, 3'd0}) begin
            errors++;
            $display("FAIL ps1_result: pass=%b ffvalid=%b err=%0d ffv=%0d required 0 1 5 0",
                     bus0.pass, bus0.first_fail_valid, bus0.err_count, bus0.first_fail_vec);
        end
        fault = 0;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        checks++;
        if (st0() !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0}) begin
            errors++;
            $display("FAIL restart_clear: status=%b required 10000000000000", st0());
        end
        e = 1;
        while (bus0.done !== 1'b1 && e < 200) begin
            tick();
            e++;
        end
        checks++;
        if ({bus0.done, bus0.pass, bus0.err_count} !== {1'b1, 1'b1, 4'd0} || e != 25) begin
            errors++;
            $display("FAIL restart_result: done=%b pass=%b err=%0d edge=%0d required 1 1 0 25",
                     bus0.done, bus0.pass, bus0.err_count, e);
        end
    endtask

    task automatic test_abort();
        fault = 1;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        repeat (9) tick();
        checks++;
        if ({v0, bus0.err_count, bus0.busy} !== {3'd3, 4'd3, 1'b1}) begin
            errors++;
            $display("FAIL abort_pre: drv=%0d err=%0d busy=%b required 3 3 1", v0, bus0.err_count, bus0.busy);
        end
        bus0.abort = 1'b1;
        tick();
        bus0.abort = 1'b0;
        checks++;
        if (st0() !== 14'd0) begin errors++; $display("FAIL abort_post: status=%b required 0", st0()); end
        bus0.start = 1'b1;
        bus0.abort = 1'b1;
        tick();
        bus0.start = 1'b0;
        bus0.abort = 1'b0;
        checks++;
        if (bus0.busy !== 1'b0) begin errors++; $display("FAIL start_abort_busy: got %b required 0", bus0.busy); end
        repeat (3) tick();
        checks++;
        if (st0() !== 14'd0) begin errors++; $display("FAIL start_abort_idle: status=%b required 0", st0()); end
    endtask

    task automatic test_reset_midrun();
        fault = 0;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        repeat (15) tick();
        checks++;
        if ({bus0.busy, v0} !== {1'b1, 3'd5}) begin
            errors++;
            $display("FAIL rst_mid_pre: busy=%b drv=%0d required 1 5", bus0.busy, v0);
        end
        #2;
        n_reset = 1'b0;
        #1;
        checks++;
        if (st0() !== 14'd0) begin errors++; $display("FAIL rst_mid_async: status=%b required 0", st0()); end
        @(negedge clk);
        n_reset = 1'b1;
        tick();
        checks++;
        if (st0() !== 14'd0) begin errors++; $display("FAIL rst_mid_after: status=%b required 0", st0()); end
    endtask

    task automatic test_start_ignored();
        int e;
        fault = 0;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        e = 1;
        while (bus0.done !== 1'b1 && e < 200) begin
            if (e == 5 || e == 12) bus0.start = 1'b1;
            tick();
            bus0.start = 1'b0;
            e++;
        end
        checks++;
        if (e != 25) begin errors++; $display("FAIL restart_ignored_latency: got %0d required 25", e); end
        checks++;
        if ({bus0.pass, bus0.err_count} !== {1'b1, 4'd0}) begin
            errors++;
            $display("FAIL restart_ignored_result: pass=%b err=%0d required 1 0", bus0.pass, bus0.err_count);
        end
    endtask

    task automatic test_settle1();
        int e;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        e = 1;
        while (bus1.done !== 1'b1 && e < 200) begin
            if (e == 3) begin
                checks++;
                if ({bus1.busy, v1} !== {1'b1, 3'd1}) begin
                    errors++;
                    $display("FAIL settle1_drive: busy=%b drv=%0d required 1 1", bus1.busy, v1);
                end
            end
            tick();
            e++;
        end
        checks++;
        if (e != 17) begin errors++; $display("FAIL settle1_latency: got %0d required 17", e); end
        checks++;
        if (st1() !== {1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 3'd0, 3'd0}) begin
            errors++;
            $display("FAIL settle1_result: status=%b required 01100000000000", st1());
        end
    endtask

    initial begin
        test_reset();
        test_good_run();
        test_q_stuck0();
        test_p_stuck0();
        test_p_stuck1_restart();
        test_abort();
        test_reset_midrun();
        test_start_ignored();
        test_settle1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
